fetch_pc_ras: RTL

- Parametrised next-generation program counter / fetch sequencer for the CPU core.
- Generalises PC width and branch offset width. Supports a selectable branch condition set, absolute jumps, and call/return through an internal return-address stack (RAS) of configurable depth.
- Sits at the front of the pipeline. `pc` drives instruction memory address. Branch/jump/call/ret controls come from decode; `cmp` comes from the ALU.

---
 rtl/fetch_pc_ras.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_ras.sv
// Fetch-stage program counter with conditional branches, absolute jumps and
// call/return through a circular return-address stack.
module fetch_pc_ras #(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned CMP_W     = 8,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             halt,
    input  logic                             stall,
    input  logic                             br_valid,
    input  logic [2:0]                       br_cond,
    input  logic [CMP_W-1:0]                 cmp,
    input  logic [PC_W-1:0]                  br_off,
    input  logic                             jmp_valid,
    input  logic                             call,
    input  logic                             ret,
    input  logic [PC_W-1:0]                  jmp_target,
    output logic [PC_W-1:0]                  pc,
    output logic                             redirect,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_ovf,
    output logic                             ras_unf
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  pc_q, pc_d, pc_inc;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [PTR_W-1:0] wp_q, wp_d, wp_inc, wp_dec;
    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic             push;
    logic             br_taken;
    logic             cmp_neg, cmp_zero;

    assign pc_inc   = pc_q + 1'b1;
    assign cmp_neg  = cmp[CMP_W-1];
    assign cmp_zero = (cmp == '0);

    // wp_q points at the next free slot; the top entry sits just below it.
    assign wp_inc = (wp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : wp_q - 1'b1;

    always_comb begin
        case (br_cond)
            3'b000:  br_taken = cmp_neg;
            3'b001:  br_taken = !cmp_zero;
            3'b010:  br_taken = cmp_zero;
            3'b011:  br_taken = !cmp_neg;
            3'b100:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        redirect_d = 1'b0;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        wp_d       = wp_q;
        push       = 1'b0;
        if (halt || stall) begin
            pc_d = pc_q;
        end else if (call) begin
            // A full stack overwrites its oldest slot, which is where wp_q points.
            push       = 1'b1;
            pc_d       = jmp_target;
            redirect_d = 1'b1;
            wp_d       = wp_inc;
            if (cnt_q == CNT_W'(RAS_DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (ret) begin
            if (cnt_q != '0) begin
                pc_d       = ras_mem[wp_dec];
                redirect_d = 1'b1;
                wp_d       = wp_dec;
                cnt_d      = cnt_q - 1'b1;
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (jmp_valid) begin
            pc_d       = jmp_target;
            redirect_d = 1'b1;
        end else if (br_valid && br_taken) begin
            pc_d       = pc_q + br_off;
            redirect_d = 1'b1;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            wp_q       <= '0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            wp_q       <= wp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ras_mem[wp_q] <= pc_inc;
        end
    end

    assign pc        = pc_q;
    assign redirect  = redirect_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule
